// File: rtl/pc_sequencer.sv
// Next-PC sequencer: fetches the word at PCout, waits for the execute resolution, then strobes updatePC.
// Defining PC_ALIGN_CHECK_EN halts the sequencer on misaligned taken targets.
module pc_sequencer #(
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCout,
  output logic [31:0] PCin,
  output logic        updatePC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_RESOLVE = 2'd1,
    S_UPDATE  = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pcin;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_upd;
  logic        r_req;
  logic        r_ivld;
  logic        r_halted;
  logic        r_misalign;

  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;
  logic        w_bad_target;
  logic        w_fetch_done;

  // Sequential successor; plain 32-bit addition wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  // PC_STEP is a power of two, so the low bits below it must be clear.
  function automatic logic is_misaligned(input logic [31:0] tgt);
    return |(tgt & (PC_STEP - 32'd1));
  endfunction

  assign w_bad_target = br_taken & is_misaligned(br_target);
`else
  assign w_bad_target = 1'b0;
`endif

  assign w_seq_pc     = seq_pc(PCout);
  assign w_next_pc    = br_taken ? br_target : w_seq_pc;
  assign w_fetch_done = r_req & imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pcin     <= RESET_PC;
      r_instr    <= '0;
      r_retired  <= '0;
      r_upd      <= 1'b0;
      r_req      <= 1'b0;
      r_ivld     <= 1'b0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_upd  <= 1'b0;
      r_ivld <= 1'b0;
      case (r_state)
        // A request is only live once r_req is up, so the first cycle after reset never accepts data.
        S_FETCH: begin
          r_req <= 1'b1;
          if (w_fetch_done) begin
            r_instr <= imem_rdata;
            r_ivld  <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_req <= 1'b0;
          if (halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else if (br_valid) begin
            if (w_bad_target) begin
              r_halted   <= 1'b1;
              r_misalign <= 1'b1;
              r_state    <= S_HALTED;
            end else begin
              r_pcin  <= w_next_pc;
              r_upd   <= 1'b1;
              r_state <= S_UPDATE;
            end
          end
        end
        // The request is raised together with the return to FETCH so the loop stays at three cycles.
        S_UPDATE: begin
          r_retired <= r_retired + 32'd1;
          r_req     <= 1'b1;
          r_state   <= S_FETCH;
        end
        S_HALTED: begin
          r_req    <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Reset in the UPDATE cycle must keep the PC register from loading.
  assign updatePC    = r_upd & ~reset;
  assign PCin        = r_pcin;
  assign imem_req    = r_req;
  assign imem_addr   = PCout;
  assign instr       = r_instr;
  assign instr_valid = r_ivld;
  assign halted      = r_halted;
  assign misalign    = r_misalign;
  assign retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a program-level PC model feeds expected fetch words and next-PC values.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCout, PCin, imem_addr, imem_rdata, instr, br_target, retired;
  logic        updatePC, imem_req, imem_ready, instr_valid;
  logic        br_valid, br_taken, halt, halted, misalign;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_upd[$];
  int          upd_cycles[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] last_pcin;
  logic [31:0] mon_exp;

  pc_sequencer #(.PC_STEP(PC_STEP), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .PCout(PCout), .PCin(PCin), .updatePC(updatePC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .halt(halt), .halted(halted), .misalign(misalign), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program counter register the sequencer drives.
  always @(posedge clk) begin
    if (reset) PCout <= RESET_PC;
    else if (updatePC) PCout <= PCin;
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign imem_rdata = imem_ready ? memfn(imem_addr) : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc > 40000) begin
      $display("FAIL watchdog: cycles=%0d limit=40000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an instruction or a PC update.
  always @(negedge clk) begin
    if (reset) begin
      last_pcin = RESET_PC;
    end else begin
      if (instr_valid) begin
        if (q_instr.size() == 0) check("unexpected_instr_valid", instr_valid, 1'b0);
        else begin
          mon_exp = q_instr.pop_front();
          check("instr", instr, mon_exp);
        end
      end
      if (updatePC) begin
        if (q_upd.size() == 0) check("unexpected_updatePC", updatePC, 1'b0);
        else begin
          mon_exp = q_upd.pop_front();
          check("PCin", PCin, mon_exp);
        end
        last_pcin = PCin;
        upd_cycles.push_back(cyc);
      end else begin
        check("PCin_stable", PCin, last_pcin);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_target = '0; halt = 1'b0;
    step(); step();
    q_instr.delete(); q_upd.delete(); upd_cycles.delete();
    m_pc = RESET_PC; m_ret = '0;
    reset = 1'b0;
  endtask

  // One instruction at program level: fetch at m_pc with wf wait states, resolve after wr idle cycles.
  task automatic run_instr(input logic tk, input logic [31:0] tgt, input int wf, input int wr,
                           input logic hlt);
    int n;
    logic bad;
    logic [31:0] nxt;
    q_instr.push_back(memfn(m_pc));
    n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      br_valid = 1'($urandom_range(0, 1)); br_taken = 1'b1; br_target = $urandom;
      step();
      n++;
    end
    br_valid = 1'b0;
    check("fetch_started", imem_req, 1'b1);
    for (int i = 0; i < wf; i++) begin
      imem_ready = 1'b0; br_valid = 1'($urandom_range(0, 1)); br_target = $urandom;
      check("req_held", imem_req, 1'b1);
      check("fetch_addr", imem_addr, m_pc);
      step();
    end
    br_valid = 1'b0; imem_ready = 1'b1;
    check("req_held", imem_req, 1'b1);
    check("fetch_addr", imem_addr, m_pc);
    step();
    imem_ready = 1'b0;
    check("instr_valid_pulse", instr_valid, 1'b1);
    check("req_dropped", imem_req, 1'b0);
    for (int i = 0; i < wr; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      step();
    end
    imem_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    bad = tk && ((tgt % PC_STEP) != 0);
`else
    bad = 1'b0;
`endif
    br_valid = 1'b1; br_taken = tk; br_target = tgt; halt = hlt;
    if (!hlt && !bad) begin
      nxt = tk ? tgt : m_pc + PC_STEP;
      q_upd.push_back(nxt);
      m_pc = nxt;
      m_ret = m_ret + 1;
    end
    step();
    br_valid = 1'b0; br_taken = 1'b0; halt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_target = '0; halt = 1'b0;
    step(); step();
    check("rst_PCin", PCin, RESET_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_updatePC", updatePC, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_misalign", misalign, 1'b0);

    // Sequential flow, zero-wait memory: PCin 4, 8, 12, one update every third cycle.
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    step();
    check("seq_retired", retired, 32'd3);
    check("seq_upd_count", upd_cycles.size(), 3);
    if (upd_cycles.size() == 3) begin
      check("seq_period_a", upd_cycles[1] - upd_cycles[0], 3);
      check("seq_period_b", upd_cycles[2] - upd_cycles[1], 3);
    end

    // Slow memory: five wait states, request and address held throughout.
    run_instr(1'b0, 32'h0, 5, 2, 1'b0);
    step();
    check("slow_retired", retired, m_ret);

    // Taken branch to 0x100 at PC 8, then wrap from 0xFFFFFFFC to 0.
    do_reset();
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b1, 32'h100, 0, 1, 1'b0);
    run_instr(1'b1, 32'hFFFFFFFC, 1, 0, 1'b0);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    step();
    check("br_retired", retired, m_ret);

    // halt beats a same-cycle br_valid and holds until reset.
    do_reset();
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b1, 32'h200, 0, 1, 1'b1);
    check("halt_halted", halted, 1'b1);
    check("halt_no_update", updatePC, 1'b0);
    for (int i = 0; i < 8; i++) begin
      imem_ready = 1'($urandom_range(0, 1)); br_valid = 1'($urandom_range(0, 1));
      br_taken = 1'b1; br_target = 32'h40; halt = 1'($urandom_range(0, 1));
      step();
      check("halt_stays", halted, 1'b1);
      check("halt_no_req", imem_req, 1'b0);
      check("halt_retired", retired, m_ret);
    end
    do_reset();
    check("halt_cleared", halted, 1'b0);

    // Reset in the UPDATE cycle suppresses the strobe and restarts at RESET_PC.
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b1, 32'h80, 0, 0, 1'b0);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    reset = 1'b1;
    #1;
    check("rstupd_no_strobe", updatePC, 1'b0);
    q_upd.delete();
    step();
    reset = 1'b0;
    m_pc = RESET_PC; m_ret = '0; q_instr.delete();
    check("rstupd_retired", retired, 32'h0);
    check("rstupd_PCin", PCin, RESET_PC);
    step();
    check("rstupd_fetch_req", imem_req, 1'b1);
    check("rstupd_fetch_addr", imem_addr, RESET_PC);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);

    // Reset while a fetch is pending drops the request on the next cycle.
    step();
    check("pend_req_up", imem_req, 1'b1);
    reset = 1'b1;
    step();
    check("pend_req_dropped", imem_req, 1'b0);
    do_reset();

    // Misaligned taken target.
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(1'b1, 32'h102, 0, 0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_misalign", misalign, 1'b1);
    check("mis_halted", halted, 1'b1);
    check("mis_no_update", updatePC, 1'b0);
    step(); step();
    check("mis_retired", retired, m_ret);
    check("mis_no_req", imem_req, 1'b0);
`else
    check("mis_misalign", misalign, 1'b0);
    run_instr(1'b0, 32'h0, 0, 0, 1'b0);
    step();
    check("mis_retired", retired, m_ret);
    check("mis_misalign_after", misalign, 1'b0);
`endif

    // Randomised instruction stream with aligned targets.
    do_reset();
    for (int i = 0; i < 40; i++)
      run_instr(1'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    step();
    check("rand_retired", retired, m_ret);
    check("rand_q_upd_drained", q_upd.size(), 0);
    check("rand_q_instr_drained", q_instr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
